// File: rtl/chipio_responder.sv
// chipio_responder: peripheral-side responder for the CPU chipio port bus.
// It serves a bank of output registers, 2-flop synchronized input ports and
// a TX/RX FIFO pair. Every strobe gets registered read data and a one-cycle ack.
// The optional sticky error flag (status bit4) is built when the macro
// CHIPIO_UNMAPPED_ERR_EN is defined.
module chipio_responder #(
  parameter int DW         = 16,
  parameter int NUM_OUT    = 4,
  parameter int NUM_IN     = 4,
  parameter int FIFO_DEPTH = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  chipio_en,
  input  logic                  chipio_rw,
  input  logic [15:0]           chipio_port,
  input  logic [DW-1:0]         chipio_data,
  output logic [DW-1:0]         chipio_rdata,
  output logic                  chipio_ack,
  output logic [NUM_OUT*DW-1:0] gpio_out,
  input  logic [NUM_IN*DW-1:0]  gpio_in,
  output logic [DW-1:0]         tx_data,
  output logic                  tx_valid,
  input  logic                  tx_ready,
  input  logic [DW-1:0]         rx_data,
  input  logic                  rx_valid,
  output logic                  rx_ready
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = AW + 1;
  localparam logic [15:0] PORT_IN_BASE = 16'h0010;
  localparam logic [15:0] PORT_FIFO    = 16'h0020;
  localparam logic [15:0] PORT_STATUS  = 16'h0021;

  logic [DW-1:0]        out_regs [NUM_OUT];
  logic [NUM_IN*DW-1:0] gpio_sync1, gpio_sync2;

  logic [DW-1:0] tx_mem [FIFO_DEPTH];
  logic [DW-1:0] rx_mem [FIFO_DEPTH];
  logic [AW-1:0] tx_wr_ptr, tx_rd_ptr, rx_wr_ptr, rx_rd_ptr;
  logic [CW-1:0] tx_count, rx_count;

  logic tx_full, tx_empty, rx_full, rx_empty;
  logic tx_push, tx_pop, rx_push, rx_pop;
  logic is_fifo;
  logic err_flag;
  logic [7:0]    rx_count_sat;
  logic [DW-1:0] status;
  logic [DW-1:0] rd_value;

  assign tx_full  = (tx_count == CW'(FIFO_DEPTH));
  assign tx_empty = (tx_count == '0);
  assign rx_full  = (rx_count == CW'(FIFO_DEPTH));
  assign rx_empty = (rx_count == '0);

  assign is_fifo = (chipio_port == PORT_FIFO);
  assign tx_push = chipio_en & ~chipio_rw & is_fifo & ~tx_full;
  assign tx_pop  = tx_valid & tx_ready;
  assign rx_push = rx_valid & rx_ready;
  assign rx_pop  = chipio_en & chipio_rw & is_fifo & ~rx_empty;

  assign tx_valid = ~tx_empty;
  assign rx_ready = ~rx_full;
  assign tx_data  = tx_mem[tx_rd_ptr];

  assign rx_count_sat = (int'(rx_count) > 255) ? 8'hFF : 8'(rx_count);

  for (genvar k = 0; k < NUM_OUT; k++) begin : g_out
    assign gpio_out[k*DW +: DW] = out_regs[k];
  end

  // Two-flop synchronizer for the asynchronous input ports.
  always_ff @(posedge clk or negedge rst) begin
    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    if (!rst) begin
      gpio_sync1 <= '0;
      gpio_sync2 <= '0;
    end else begin
      gpio_sync1 <= gpio_in;
      gpio_sync2 <= gpio_sync1;
    end
  end

  // Output register bank, loaded by writes to ports 0..NUM_OUT-1.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int k = 0; k < NUM_OUT; k++) out_regs[k] <= '0;
    end else if (chipio_en && !chipio_rw) begin
      for (int k = 0; k < NUM_OUT; k++)
        if (chipio_port == 16'(k)) out_regs[k] <= chipio_data;
    end
  end

  // FIFO storage: contents are meaningless until counted in.
  always_ff @(posedge clk) begin
    // NOTE: FIFO RAMs carry no reset; the count and pointers alone define validity.
    if (tx_push) tx_mem[tx_wr_ptr] <= chipio_data;
    if (rx_push) rx_mem[rx_wr_ptr] <= rx_data;
  end

  // TX FIFO pointers and occupancy.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      tx_wr_ptr <= '0;
      tx_rd_ptr <= '0;
      tx_count  <= '0;
    end else begin
      if (tx_push) tx_wr_ptr <= tx_wr_ptr + AW'(1);
      if (tx_pop)  tx_rd_ptr <= tx_rd_ptr + AW'(1);
      case ({tx_push, tx_pop})
        2'b10:   tx_count <= tx_count + CW'(1);
        2'b01:   tx_count <= tx_count - CW'(1);
        default: tx_count <= tx_count;
      endcase
    end
  end

  // RX FIFO pointers and occupancy.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rx_wr_ptr <= '0;
      rx_rd_ptr <= '0;
      rx_count  <= '0;
    end else begin
      if (rx_push) rx_wr_ptr <= rx_wr_ptr + AW'(1);
      if (rx_pop)  rx_rd_ptr <= rx_rd_ptr + AW'(1);
      case ({rx_push, rx_pop})
        2'b10:   rx_count <= rx_count + CW'(1);
        2'b01:   rx_count <= rx_count - CW'(1);
        default: rx_count <= rx_count;
      endcase
    end
  end

`ifdef CHIPIO_UNMAPPED_ERR_EN
  logic mapped;
  logic err_event;
  logic status_read;

  // Classify the current strobe as mapped or unmapped.
  always_comb begin
    mapped = is_fifo || (chipio_port == PORT_STATUS);
    for (int k = 0; k < NUM_OUT; k++)
      if (chipio_port == 16'(k)) mapped = 1'b1;
    for (int k = 0; k < NUM_IN; k++)
      if (chipio_port == PORT_IN_BASE + 16'(k)) mapped = 1'b1;
  end

  assign err_event   = chipio_en & (~mapped | (~chipio_rw & is_fifo & tx_full));
  assign status_read = chipio_en & chipio_rw & (chipio_port == PORT_STATUS);

  // Sticky error flag: a new event wins over the clearing status read.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)             err_flag <= 1'b0;
    else if (err_event)   err_flag <= 1'b1;
    else if (status_read) err_flag <= 1'b0;
  end
`else
  assign err_flag = 1'b0;
`endif

  // Status word assembly.
  always_comb begin
    status       = '0;
    status[0]    = tx_full;
    status[1]    = tx_empty;
    status[2]    = rx_full;
    status[3]    = rx_empty;
    status[4]    = err_flag;
    status[15:8] = rx_count_sat;
  end

  // Read-data mux for the decoded port; unmapped ports read 0.
  always_comb begin
    // NOTE: a default on entry keeps this block free of inferred latches.
    rd_value = '0;
    for (int k = 0; k < NUM_OUT; k++)
      if (chipio_port == 16'(k)) rd_value = out_regs[k];
    for (int k = 0; k < NUM_IN; k++)
      if (chipio_port == PORT_IN_BASE + 16'(k)) rd_value = gpio_sync2[k*DW +: DW];
    if (is_fifo)                    rd_value = rx_empty ? '0 : rx_mem[rx_rd_ptr];
    if (chipio_port == PORT_STATUS) rd_value = status;
  end

  // Registered response: ack and read data live for exactly one cycle.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      chipio_ack   <= 1'b0;
      chipio_rdata <= '0;
    end else begin
      chipio_ack   <= chipio_en;
      chipio_rdata <= (chipio_en && chipio_rw) ? rd_value : '0;
    end
  end

endmodule

// File: doc/chipio_responder.md
Name: chipio_responder

Overview:
- Peripheral-side responder for the CPU's chipio port bus. The CPU issues single-cycle chipio_en strobes carrying port, rw and data.
- This block decodes the port number and serves:
  - a bank of output registers,
  - synchronized input ports,
  - a TX/RX FIFO pair for a byte/word stream.
- Returns registered read data with a one-cycle ack.

Parameters:
- DW, 16, data width of the chipio bus and all ports
- NUM_OUT, 4, number of output registers (1..16)
- NUM_IN, 4, number of input ports (1..16)
- FIFO_DEPTH, 8, entries per FIFO; power of two, 2..256

Ports:
- clk  input  1  system clock, all logic on rising edge
- rst  input  1  asynchronous, active-low reset
- chipio_en  input  1  transaction strobe, one cycle per transaction
- chipio_rw  input  1  1 = read, 0 = write
- chipio_port  input  16  port number
- chipio_data  input  DW  write data
- chipio_rdata  output  DW  read data, valid when chipio_ack=1
- chipio_ack  output  1  one-cycle completion pulse
- gpio_out  output  NUM_OUT*DW  packed output registers; register k at bits [k*DW +: DW]
- gpio_in  input  NUM_IN*DW  packed asynchronous input ports
- tx_data  output  DW  TX FIFO head
- tx_valid  output  1  TX FIFO not empty
- tx_ready  input  1  consumer pops the head on tx_valid & tx_ready
- rx_data  input  DW  producer word
- rx_valid  input  1  producer push request
- rx_ready  output  1  RX FIFO not full

Behaviour:
- Reset (rst=0, async):
  - chipio_rdata=0, chipio_ack=0, gpio_out all 0.
  - Both FIFOs empty, pointers and counts 0; tx_valid=0, rx_ready=1.
  - Sync flops cleared.
- Input sync: gpio_in passes through a 2-flop synchronizer. A read returns the value present at gpio_in 2 cycles earlier (a read strobe at cycle t returns gpio_in from cycle t-2 or later).
- Transaction timing: chipio_en=1 at edge t is decoded at t. chipio_ack=1 and chipio_rdata are valid for exactly the following cycle.
  - Back-to-back strobes are each served; no stall, no busy state.
  - chipio_rdata=0 on writes and holds 0 when ack=0.
- Port map:
  - 0x00..NUM_OUT-1: output register k. Write loads it. Read returns current value.
  - 0x10..0x10+NUM_IN-1: synchronized input k. Read only; writes ignored.
  - 0x20: FIFO data port.
    - Write pushes chipio_data into TX FIFO.
    - Read pops the RX FIFO head into chipio_rdata.
  - 0x21: status, read only.
    - bit0 tx_full, bit1 tx_empty, bit2 rx_full, bit3 rx_empty.
    - bits[15:8] rx_count, saturating at 255.
    - Other bits 0.
  - Any other port: read returns 0, write ignored, ack still issued.
- FIFOs: circular buffers, wrap-around pointers, count register.
  - Full when count==FIFO_DEPTH; empty when count==0.
- TX push while full: word dropped, no state change.
- TX push and pop in the same cycle:
  - When not full: both happen; count unchanged.
  - When full: push dropped, pop proceeds. Full is evaluated on pre-edge state.
  - When empty: push happens; the pop is not possible since tx_valid=0.
- RX pop while empty: returns 0, no underflow.
- RX push occurs on rx_valid & rx_ready. rx_ready=0 when full, so pushes are refused, never dropped silently.
  - RX push and CPU pop in the same cycle: both happen; the pop returns the old head.
- tx_data always shows the TX head, combinational from RAM at the read pointer.
- Reset mid-operation: any pending ack is cancelled, FIFO contents are discarded, and no ack appears after reset is released.

Optional Feature:
- Macro: CHIPIO_UNMAPPED_ERR_EN
- Defined:
  - A sticky error flag sets on any unmapped-port access or on a TX push while full.
  - The flag appears as status bit4 and is cleared by a status read. The read that clears it still returns 1.
  - If an error event coincides with the clearing read, the flag remains set.
- Undefined: no flag; status bit4 reads 0; behaviour otherwise identical.

Test Plan:
- Reset, then write 0x1234 to port 0x02 -> ack the next cycle. gpio_out[47:32]=0x1234; a read of port 0x02 returns 0x1234; other output registers stay 0.
- Drive gpio_in[15:0]=0xBEEF, wait 2 cycles, read port 0x10 -> chipio_rdata=0xBEEF with ack=1.
- Push 9 words 1..9 to port 0x20 with tx_ready=0 (DEPTH 8) -> status reads tx_full=1. Raising tx_ready drains exactly 1..8, then tx_valid=0 and tx_empty=1.
- Producer pushes 0xA0..0xA7 until rx_ready=0, then 10 pops via port 0x20 -> returns 0xA0..0xA7 then 0,0. Status after the pops: rx_empty=1, rx_count=0.
- Read port 0x55 -> rdata=0, ack=1. With CHIPIO_UNMAPPED_ERR_EN defined, the next status read shows bit4=1 and the following status read shows bit4=0.
- Issue a port-0x02 write, assert rst=0 on the next cycle -> ack is never seen and gpio_out=0 after release.
